prio_grant_encoder: RTL
=======================

Name: prio_grant_encoder

Overview:
Parametrised, registered priority encoder/arbiter. It generalises the 4-bit MSB-first casex priority decode to N request lines and adds a runtime round-robin mode and a valid/ready handshake on both sides. Each accepted request vector produces one registered grant (one-hot plus index), or a "none" indication when no line is set. It sits between request sources (interrupt or channel lines) and a single shared consumer.

Parameters:
N, 8, number of request lines; legal range 2..64.
IDX_W, $clog2(N), width of the grant index; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  request vector valid
in_ready  output  1  block can accept a vector this cycle
req  input  N  request lines; bit N-1 has the highest fixed priority
rr_en  input  1  1 = round-robin mode, 0 = fixed MSB-first priority; sampled on accept
out_valid  output  1  grant result valid
out_ready  input  1  consumer accepts the result
grant  output  N  one-hot grant; all zeros when out_none=1
grant_idx  output  IDX_W  index of the granted line; 0 when out_none=1
out_none  output  1  the accepted vector had no bits set

Behaviour:
- Reset: when rst_n=0 at a clk edge, the next state is out_valid=0, grant=0, grant_idx=0, out_none=0, and the internal pointer ptr=0. Reset overrides every other event, including an in-flight handshake.
- Ready rule: in_ready = !out_valid || out_ready. This is combinational and registered-bypass only; there is no skid buffer.
- Accept: when in_valid && in_ready, the result is registered at the same edge. out_valid=1 from the next cycle, so latency is 1 cycle.
- Drain: if out_valid && out_ready && !(in_valid && in_ready), then out_valid goes to 0 next cycle. The other outputs hold their last values.
- Stall: while out_valid=1 and out_ready=0, all outputs and ptr hold. in_ready=0, and req is ignored.
- Back-to-back: an accept in the same cycle as a drain loads the new result with out_valid staying at 1.
- Fixed mode (rr_en=0): the grant goes to the highest set index, N-1 down to 0.
- Round-robin mode (rr_en=1):
  - The search starts at index (ptr-1) mod N and proceeds downward with wrap-around (ptr-1, ptr-2, ..., 0, N-1, ..., ptr).
  - The first set bit wins.
  - Because ptr=0 after reset, the first search starts at N-1, which is identical to fixed mode.
- Pointer update: on every accepted non-zero vector, in either mode, ptr <= granted index. Mode switches between requests are therefore well-defined.
- Empty vector (req=0 on accept): out_none=1, grant=0, grant_idx=0, ptr unchanged, out_valid=1 (the result is still handshaked).
- Single-bit vector: that bit is granted in both modes.
- Output invariants:
  - grant is always zero or exactly one-hot.
  - When out_none=0, grant == (1 << grant_idx).
- Index arithmetic: the index is modulo N, including for non-power-of-2 N. The wrap from 0 goes to N-1, never to 2^IDX_W-1.
- Unknowns: no X/Z-tolerant matching in RTL. X/Z on req while in_valid=1 is illegal, and the bench asserts on it.
- Implementation: a combinational search function feeding the output register. No latches. Every output is driven from a flop.

Test Plan:
1. Reset and fixed mode (N=8, rr_en=0): rst_n=0 for 2 cycles gives all outputs 0 and in_ready=1. Then req=8'b0100_1010 with in_valid=1, out_ready=1 gives, one cycle later, out_valid=1, grant=8'b0100_0000, grant_idx=6.
2. Round-robin rotation (N=8, rr_en=1, out_ready=1): req=8'b1000_0001 applied 3 times back-to-back gives grant_idx 7, 0, 7. With rr_en=0 the same sequence gives 7, 7, 7.
3. Empty and wrap (N=8, rr_en=1):
   - Accept req=0 → out_none=1, grant=0, ptr unchanged.
   - From ptr=0, req=8'b0000_0100 → idx 2.
   - Then req=8'b0000_0110 → idx 1.
   - Then req=8'b0000_0110 → wraps to idx 2.
4. Backpressure: hold out_ready=0 after the first result.
   - in_ready=0, and grant and grant_idx stay stable for 5 cycles while req changes.
   - Raising out_ready with in_valid=1 gives in_ready=1 in that cycle, and the new result appears the next cycle with no bubble.
5. Reset mid-operation: with out_valid=1 and ptr=5, pulse rst_n=0 for 1 cycle. Next cycle out_valid=0 and grant=0. In RR mode the following req=8'b1010_0000 grants idx 7, confirming ptr was reset to 0.
6. Non-power-of-2 instance (N=5, rr_en=1): from reset, req=5'b10001 gives idx 4, 0, 4. grant_idx never exceeds 4. Check the one-hot invariant on every out_valid cycle.

Source files
------------

// File: rtl/prio_grant_encoder_if.sv
// Request/grant bus for prio_grant_encoder.
// The slave side is the encoder itself; the master side is whatever drives
// request vectors in and consumes grant results.
interface prio_grant_encoder_if #(
    parameter int N = 8
);
    localparam int IDX_W = $clog2(N);

    // Request side
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     req;
    logic             rr_en;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             out_none;

    modport master (
        output in_valid,
        output req,
        output rr_en,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  grant,
        input  grant_idx,
        input  out_none
    );

    modport slave (
        input  in_valid,
        input  req,
        input  rr_en,
        input  out_ready,
        output in_ready,
        output out_valid,
        output grant,
        output grant_idx,
        output out_none
    );
endinterface

// File: rtl/prio_grant_encoder.sv
// Registered N-line priority encoder / arbiter.
// Fixed mode grants the highest set line; round-robin mode searches
// downward from one below the last granted line, wrapping modulo N.
// Each accepted vector yields one registered result after one cycle.
module prio_grant_encoder #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prio_grant_encoder_if.slave   bus
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Downward wrap-around search. The start index is N-1 in fixed mode and
    // (ptr-1) mod N in round-robin mode; the first set bit wins. Index steps
    // wrap from 0 to N-1, never to 2^IDX_W-1, so odd N stays in range.
    function automatic pick_t search(
        input logic [N-1:0]     vec,
        input logic             rr,
        input logic [IDX_W-1:0] last
    );
        pick_t            res;
        logic [IDX_W-1:0] pos;
        // NOTE: function/comb locals use blocking '=' so each loop iteration
        // sees the value written by the previous one.
        res = '0;
        if (!rr || last == '0) begin
            pos = LAST_IDX;
        end else begin
            pos = last - IDX_W'(1);
        end
        for (int k = 0; k < N; k++) begin
            if (!res.hit && vec[pos]) begin
                res.hit = 1'b1;
                res.idx = pos;
            end
            pos = (pos == '0) ? LAST_IDX : pos - IDX_W'(1);
        end
        return res;
    endfunction

    // Registered state
    logic             out_valid_q;
    logic [N-1:0]     grant_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic             out_none_q;
    logic [IDX_W-1:0] ptr;

    // Combinational next-result path
    pick_t            pick;
    logic [N-1:0]     grant_next;
    logic             in_ready;
    logic             accept;

    // Accept whenever the output slot is empty or being drained this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Search the incoming vector and form the one-hot grant.
    always_comb begin
        // NOTE: every comb output gets a default before any branch so no
        // path leaves it unassigned (which would infer a latch).
        grant_next = '0;
        pick       = search(bus.req, bus.rr_en, ptr);
        if (pick.hit) begin
            grant_next[pick.idx] = 1'b1;
        end
    end

    // Result register and round-robin pointer with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking '<=' so all flops update from values
        // sampled at the same edge; reset is synchronous and wins over any
        // handshake in progress.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            out_none_q  <= 1'b0;
            ptr         <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            grant_q     <= grant_next;
            grant_idx_q <= pick.hit ? pick.idx : '0;
            out_none_q  <= !pick.hit;
            if (pick.hit) begin
                ptr <= pick.idx;
            end
        end else if (bus.out_ready) begin
            // Drain with no replacement: payload holds, only valid drops.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.grant     = grant_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.out_none  = out_none_q;

endmodule
